// File: rtl/bias_add_11_pkg.sv
// Shared sizing constants and state encoding for the layer-11 bias stage.
package bias_add_11_pkg;

   localparam int KERN_S_K_11 = 4;
   localparam int COEFF_WIDTH = 16;
   localparam int ACC_WIDTH   = 32;

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Counter width for a modulo-n counter, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder: sign-extended bias plus accumulator, clamped to ACC_W.
module sat_add #(
   parameter int ACC_W   = 32,
   parameter int COEFF_W = 16
) (
   input  logic [ACC_W-1:0]   acc_i,
   input  logic [COEFF_W-1:0] bias_i,
   output logic [ACC_W-1:0]   sum_o
);

   logic [ACC_W:0] wide_s;

   // One guard bit is enough: disagreement between the top two bits means overflow.
   always_comb begin
      wide_s = {acc_i[ACC_W-1], acc_i} + {{(ACC_W + 1 - COEFF_W){bias_i[COEFF_W-1]}}, bias_i};
      if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
         sum_o = wide_s[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
      end else begin
         sum_o = wide_s[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/bias_add_11.sv
// Layer-11 bias stage: loads N_CH biases per frame, then adds them channel-wise to the accumulator stream.
module bias_add_11
   import bias_add_11_pkg::*;
#(
   parameter int N_CH    = KERN_S_K_11,
   parameter int N_PIX   = 64,
   parameter int COEFF_W = COEFF_WIDTH,
   parameter int ACC_W   = ACC_WIDTH
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic [COEFF_W-1:0] bias_V_dout,
   input  logic               bias_V_empty_n,
   output logic               bias_V_read,
   input  logic [ACC_W-1:0]   acc_V_dout,
   input  logic               acc_V_empty_n,
   output logic               acc_V_read,
   output logic [ACC_W-1:0]   output_V_din,
   input  logic               output_V_full_n,
   output logic               output_V_write,
   output logic               frame_done
);

   localparam int CH_W  = cnt_width(N_CH);
   localparam int PIX_W = cnt_width(N_PIX);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

   state_e             state_q, state_d;
   logic [CH_W-1:0]    ld_cnt_q, ld_cnt_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [PIX_W-1:0]   pix_q, pix_d;
   logic [COEFF_W-1:0] bias_mem_q [N_CH];
   logic [COEFF_W-1:0] bias_mem_d [N_CH];
   logic [ACC_W-1:0]   out_q, out_d;
   logic               out_vld_q, out_vld_d;
   logic               last_q, last_d;

   logic               bias_rd_s;
   logic               acc_rd_s;
   logic               accept_s;
   logic [COEFF_W-1:0] bias_sel_s;
   logic [ACC_W-1:0]   sum_s;

   assign bias_sel_s = bias_mem_q[ch_q];

   sat_add #(
      .ACC_W   (ACC_W),
      .COEFF_W (COEFF_W)
   ) u_sat_add (
      .acc_i  (acc_V_dout),
      .bias_i (bias_sel_s),
      .sum_o  (sum_s)
   );

   always_comb begin
      state_d    = state_q;
      ld_cnt_d   = ld_cnt_q;
      ch_d       = ch_q;
      pix_d      = pix_q;
      bias_mem_d = bias_mem_q;
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      last_d     = last_q;
      bias_rd_s  = 1'b0;
      acc_rd_s   = 1'b0;
      accept_s   = out_vld_q & output_V_full_n;

      if (accept_s) begin
         out_vld_d = 1'b0;
         last_d    = 1'b0;
      end else begin
         out_vld_d = out_vld_q;
         last_d    = last_q;
      end

      case (state_q)
         ST_LOAD: begin
            bias_rd_s = bias_V_empty_n;
            if (bias_rd_s) begin
               bias_mem_d[ld_cnt_q] = bias_V_dout;
               if (ld_cnt_q == CH_LAST) begin
                  ld_cnt_d = {CH_W{1'b0}};
                  state_d  = ST_RUN;
               end else begin
                  ld_cnt_d = ld_cnt_q + CH_W'(1);
               end
            end else begin
               ld_cnt_d = ld_cnt_q;
            end
         end
         ST_RUN: begin
            // A load may coincide with draining the previous word; the load wins.
            acc_rd_s = acc_V_empty_n & (~out_vld_q | output_V_full_n);
            if (acc_rd_s) begin
               out_d     = sum_s;
               out_vld_d = 1'b1;
               last_d    = (ch_q == CH_LAST) && (pix_q == PIX_LAST);
               if (ch_q == CH_LAST) begin
                  ch_d = {CH_W{1'b0}};
                  if (pix_q == PIX_LAST) begin
                     pix_d   = {PIX_W{1'b0}};
                     state_d = ST_LOAD;
                  end else begin
                     pix_d = pix_q + PIX_W'(1);
                  end
               end else begin
                  ch_d = ch_q + CH_W'(1);
               end
            end else begin
               ch_d = ch_q;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q   <= ST_LOAD;
         ld_cnt_q  <= {CH_W{1'b0}};
         ch_q      <= {CH_W{1'b0}};
         pix_q     <= {PIX_W{1'b0}};
         out_q     <= {ACC_W{1'b0}};
         out_vld_q <= 1'b0;
         last_q    <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            bias_mem_q[i] <= {COEFF_W{1'b0}};
         end
      end else begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         ch_q       <= ch_d;
         pix_q      <= pix_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         last_q     <= last_d;
         bias_mem_q <= bias_mem_d;
      end
   end

   assign bias_V_read    = bias_rd_s;
   assign acc_V_read     = acc_rd_s;
   assign output_V_din   = out_q;
   assign output_V_write = out_vld_q;
   assign frame_done     = accept_s & last_q;

endmodule

// File: tb/tb_bias_add_11.sv
// Scoreboard bench for bias_add_11 with N_CH=4, N_PIX=2 and FWFT source/sink models.
module tb_bias_add_11;

   localparam int N_CH    = 4;
   localparam int N_PIX   = 2;
   localparam int COEFF_W = 16;
   localparam int ACC_W   = 32;
   localparam int N_WORDS = N_CH * N_PIX;

   logic               ap_clk;
   logic               ap_rst;
   logic [COEFF_W-1:0] bias_V_dout;
   logic               bias_V_empty_n;
   logic               bias_V_read;
   logic [ACC_W-1:0]   acc_V_dout;
   logic               acc_V_empty_n;
   logic               acc_V_read;
   logic [ACC_W-1:0]   output_V_din;
   logic               output_V_full_n;
   logic               output_V_write;
   logic               frame_done;

   bias_add_11 #(
      .N_CH    (N_CH),
      .N_PIX   (N_PIX),
      .COEFF_W (COEFF_W),
      .ACC_W   (ACC_W)
   ) dut (
      .ap_clk          (ap_clk),
      .ap_rst          (ap_rst),
      .bias_V_dout     (bias_V_dout),
      .bias_V_empty_n  (bias_V_empty_n),
      .bias_V_read     (bias_V_read),
      .acc_V_dout      (acc_V_dout),
      .acc_V_empty_n   (acc_V_empty_n),
      .acc_V_read      (acc_V_read),
      .output_V_din    (output_V_din),
      .output_V_full_n (output_V_full_n),
      .output_V_write  (output_V_write),
      .frame_done      (frame_done)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic [ACC_W-1:0] val;
      bit               last;
   } exp_t;

   exp_t               exp_q [$];
   logic [COEFF_W-1:0] bias_q [$];
   logic [ACC_W-1:0]   acc_q [$];

   int n_tests = 0;
   int n_fail  = 0;
   int fd_count = 0;
   bit rnd_gate = 1'b0;
   int stall_cnt = 0;

   // protocol model
   bit m_run;
   int m_ld, m_ch, m_pix;
   bit m_vld;
   bit prev_stalled;
   logic [ACC_W-1:0] prev_din;

   function automatic int sat_ref(input int a, input int b);
      longint s;
      s = longint'(a) + longint'(b);
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      return int'(s);
   endfunction

   task automatic model_clear();
      exp_q.delete();
      bias_q.delete();
      acc_q.delete();
      m_run = 1'b0;
      m_ld = 0;
      m_ch = 0;
      m_pix = 0;
      m_vld = 1'b0;
      prev_stalled = 1'b0;
      stall_cnt = 0;
   endtask

   task automatic push_frame_exp(input int b[N_CH], input int a[N_WORDS], input int e[N_WORDS]);
      exp_t x;
      for (int i = 0; i < N_CH; i++) bias_q.push_back(16'(b[i]));
      for (int j = 0; j < N_WORDS; j++) begin
         acc_q.push_back(32'(a[j]));
         x.val  = 32'(e[j]);
         x.last = (j == N_WORDS - 1);
         exp_q.push_back(x);
      end
   endtask

   task automatic push_frame(input int b[N_CH], input int a[N_WORDS]);
      int e[N_WORDS];
      for (int j = 0; j < N_WORDS; j++) e[j] = sat_ref(a[j], b[j % N_CH]);
      push_frame_exp(b, a, e);
   endtask

   // One clock cycle: drive FWFT sources/sink, check handshakes, advance the model.
   task automatic step();
      bit exp_brd, exp_ard, accept;
      exp_t x;
      @(negedge ap_clk);
      bias_V_empty_n = (bias_q.size() > 0) && (!rnd_gate || $urandom_range(0, 3) != 0);
      bias_V_dout    = (bias_q.size() > 0) ? bias_q[0] : 16'h0000;
      acc_V_empty_n  = (acc_q.size() > 0) && (!rnd_gate || $urandom_range(0, 3) != 0);
      acc_V_dout     = (acc_q.size() > 0) ? acc_q[0] : 32'h0000_0000;
      if (stall_cnt > 0) begin
         output_V_full_n = 1'b0;
         stall_cnt--;
      end else begin
         output_V_full_n = !rnd_gate || ($urandom_range(0, 2) != 0);
      end
      #1;
      exp_brd = !m_run && bias_V_empty_n;
      exp_ard = m_run && acc_V_empty_n && (!m_vld || output_V_full_n);
      accept  = m_vld && output_V_full_n;

      n_tests++;
      if (bias_V_read !== exp_brd) begin
         n_fail++;
         $display("FAIL bias_read: got %b expected %b at %0t", bias_V_read, exp_brd, $time);
      end
      n_tests++;
      if (acc_V_read !== exp_ard) begin
         n_fail++;
         $display("FAIL acc_read: got %b expected %b at %0t", acc_V_read, exp_ard, $time);
      end
      n_tests++;
      if (output_V_write !== m_vld) begin
         n_fail++;
         $display("FAIL out_write: got %b expected %b at %0t", output_V_write, m_vld, $time);
      end
      if (prev_stalled) begin
         n_tests++;
         if (output_V_din !== prev_din) begin
            n_fail++;
            $display("FAIL stall_hold: got %h expected %h at %0t", output_V_din, prev_din, $time);
         end
      end
      if (accept) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_word: got %h expected none at %0t", output_V_din, $time);
         end else begin
            x = exp_q.pop_front();
            n_tests++;
            if (output_V_din !== x.val) begin
               n_fail++;
               $display("FAIL out_data: got %h expected %h at %0t", output_V_din, x.val, $time);
            end
            n_tests++;
            if (frame_done !== x.last) begin
               n_fail++;
               $display("FAIL frame_done: got %b expected %b at %0t", frame_done, x.last, $time);
            end
         end
      end else begin
         n_tests++;
         if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_done_idle: got %b expected 0 at %0t", frame_done, $time);
         end
      end
      if (frame_done === 1'b1) fd_count++;

      prev_stalled = m_vld && !output_V_full_n;
      prev_din     = output_V_din;
      m_vld        = exp_ard ? 1'b1 : (accept ? 1'b0 : m_vld);
      if (exp_brd) begin
         void'(bias_q.pop_front());
         m_ld++;
         if (m_ld == N_CH) begin
            m_ld  = 0;
            m_run = 1'b1;
         end
      end
      if (exp_ard) begin
         void'(acc_q.pop_front());
         m_ch++;
         if (m_ch == N_CH) begin
            m_ch = 0;
            m_pix++;
            if (m_pix == N_PIX) begin
               m_pix = 0;
               m_run = 1'b0;
            end
         end
      end
   endtask

   task automatic run_drain(input string name, input int maxc);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || bias_q.size() > 0 || acc_q.size() > 0) && n < maxc) begin
         step();
         n++;
      end
      n_tests++;
      if (n >= maxc) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d pending words expected 0", name, exp_q.size());
      end
   endtask

   task automatic apply_reset();
      ap_rst          = 1'b1;
      bias_V_empty_n  = 1'b0;
      acc_V_empty_n   = 1'b0;
      bias_V_dout     = 16'h0000;
      acc_V_dout      = 32'h0000_0000;
      output_V_full_n = 1'b1;
      model_clear();
      repeat (2) @(negedge ap_clk);
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_tests++;
      if ({output_V_din, output_V_write, bias_V_read, acc_V_read, frame_done} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got din=%h wr=%b brd=%b ard=%b fd=%b expected all 0",
                  output_V_din, output_V_write, bias_V_read, acc_V_read, frame_done);
      end
      @(negedge ap_clk);
      ap_rst = 1'b0;
   endtask

   task automatic test_basic();
      int b[N_CH];
      int a[N_WORDS];
      int e[N_WORDS];
      int fd0;
      b = '{1, -2, 3, -4};
      a = '{10, 10, 10, 10, -5, -5, -5, -5};
      e = '{11, 8, 13, 6, -4, -7, -2, -9};
      fd0 = fd_count;
      push_frame_exp(b, a, e);
      run_drain("basic", 100);
      n_tests++;
      if (fd_count - fd0 != 1) begin
         n_fail++;
         $display("FAIL basic_frames: got %0d expected 1", fd_count - fd0);
      end
   endtask

   task automatic test_saturation();
      int b[N_CH];
      int a[N_WORDS];
      int e[N_WORDS];
      b = '{1, -1, 0, 0};
      a = '{32'h7FFF_FFFF, 32'h8000_0000, 7, -7, 32'h7FFF_FFFE, 32'h8000_0001, 0, 0};
      e = '{32'h7FFF_FFFF, 32'h8000_0000, 7, -7, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0};
      push_frame_exp(b, a, e);
      run_drain("saturation", 100);
   endtask

   task automatic test_backpressure();
      int b[N_CH];
      int a[N_WORDS];
      b = '{100, -200, 300, -400};
      a = '{1, 2, 3, 4, 5, 6, 7, 8};
      push_frame(b, a);
      repeat (7) step();
      stall_cnt = 5;
      run_drain("backpressure", 100);
   endtask

   task automatic test_back_to_back();
      int b1[N_CH];
      int b2[N_CH];
      int a[N_WORDS];
      int fd0;
      b1 = '{5, 6, 7, 8};
      b2 = '{-1000, 2000, -3000, 4000};
      a  = '{50, 60, 70, 80, -50, -60, -70, -80};
      fd0 = fd_count;
      push_frame(b1, a);
      push_frame(b2, a);
      run_drain("back_to_back", 200);
      n_tests++;
      if (fd_count - fd0 != 2) begin
         n_fail++;
         $display("FAIL b2b_frames: got %0d expected 2", fd_count - fd0);
      end
   endtask

   task automatic test_reset_midload();
      int b[N_CH];
      int a[N_WORDS];
      int n;
      bias_q.push_back(16'h7777);
      bias_q.push_back(16'h1234);
      n = 0;
      while (bias_q.size() > 0 && n < 20) begin
         step();
         n++;
      end
      @(posedge ap_clk);
      #2;
      bias_V_empty_n = 1'b0;
      acc_V_empty_n  = 1'b0;
      ap_rst = 1'b1;
      #1;
      n_tests++;
      if ({output_V_din, output_V_write, bias_V_read, acc_V_read, frame_done} !== 36'h0) begin
         n_fail++;
         $display("FAIL midload_reset: got din=%h wr=%b brd=%b ard=%b fd=%b expected all 0",
                  output_V_din, output_V_write, bias_V_read, acc_V_read, frame_done);
      end
      apply_reset();
      ap_rst = 1'b0;
      b = '{-9, 9, -99, 99};
      a = '{1, 1, 1, 1, 1000, 1000, 1000, 1000};
      push_frame(b, a);
      run_drain("after_reset", 100);
   endtask

   task automatic test_random();
      int b[N_CH];
      int a[N_WORDS];
      int fd0;
      fd0 = fd_count;
      rnd_gate = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N_CH; i++) b[i] = int'($signed(16'($urandom_range(0, 65535))));
         for (int j = 0; j < N_WORDS; j++) begin
            case ($urandom_range(0, 3))
               0: a[j] = 32'h7FFF_FFF0 + int'($urandom_range(0, 15));
               1: a[j] = 32'h8000_000F - int'($urandom_range(0, 15));
               default: a[j] = int'($urandom);
            endcase
         end
         push_frame(b, a);
      end
      run_drain("random", 1000);
      rnd_gate = 1'b0;
      n_tests++;
      if (fd_count - fd0 != 3) begin
         n_fail++;
         $display("FAIL random_frames: got %0d expected 3", fd_count - fd0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_reset_midload();
      test_random();
      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bias_add_11.md
# bias_add_11

Consumer end of the layer-11 bias stream. Reads the `kern_s_k_11` bias coefficients pushed by the bias ROM streamer through an ap_fifo read port and caches them in a register file. It then adds the matching channel's bias to every word of the convolution accumulator stream and writes the saturated result downstream through an ap_fifo write port. It sits between the conv_11 accumulator FIFO and the activation stage, and reloads the biases at the start of every frame.

## Interface
- N_CH, `kern_s_k_11`: output channels and number of bias words per frame.
- N_PIX, 64: output pixels per frame; each pixel carries N_CH channel words, channel-minor.
- COEFF_W, `coeff_width`: bias word width, two's complement.
- ACC_W, 32: accumulator and result width, two's complement; ACC_W ≥ COEFF_W.
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- bias_V_dout  in  COEFF_W  bias FIFO data; valid whenever bias_V_empty_n=1 (first-word-fall-through).
- bias_V_empty_n  in  1  bias FIFO holds data.
- bias_V_read  out  1  pops one bias word.
- acc_V_dout  in  ACC_W  accumulator FIFO data; first-word-fall-through.
- acc_V_empty_n  in  1  accumulator FIFO holds data.
- acc_V_read  out  1  pops one accumulator word.
- output_V_din  out  ACC_W  biased, saturated result.
- output_V_full_n  in  1  downstream FIFO can accept.
- output_V_write  out  1  pushes output_V_din.
- frame_done  out  1  one-cycle pulse when a frame's last result is written.

## Operation
- FSM has two states, LOAD and RUN. Reset state is LOAD.
- LOAD:
  - bias_V_read = bias_V_empty_n (combinational).
  - On each pop, bias_mem[ld_cnt] ← bias_V_dout and ld_cnt increments.
  - On the pop with ld_cnt = N_CH−1: ld_cnt ← 0 and the FSM moves to RUN.
  - acc_V_read = 0 throughout LOAD.
- RUN:
  - bias_V_read = 0.
  - acc_V_read = acc_V_empty_n & (!out_vld | output_V_full_n).
  - On each pop, the output register loads sat(acc_V_dout + sext(bias_mem[ch])) and out_vld ← 1.
  - ch increments and wraps at N_CH−1 → 0. On wrap, pix increments.
  - The pop with ch = N_CH−1 and pix = N_PIX−1 is the last of the frame: ch, pix ← 0 and the FSM moves to LOAD.
- Arithmetic:
  - The bias is sign-extended to ACC_W and summed at ACC_W+1 bits.
  - The result clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- Output register:
  - output_V_write = out_vld.
  - A write is accepted in any cycle with out_vld & output_V_full_n.
  - On acceptance with no simultaneous load, out_vld ← 0.
  - If a load and an acceptance occur in the same cycle, the new value replaces the old one and out_vld stays 1.
- frame_done pulses in the cycle the last result of the frame is accepted downstream.

## Timing
- Reset values: output_V_din=0, output_V_write=0, bias_V_read=0, acc_V_read=0, frame_done=0. All counters are 0, bias_mem is all zeros, state is LOAD.
- Reset is asynchronous: asserting ap_rst mid-frame aborts immediately. After release, the block restarts in LOAD with ld_cnt=0. A partially loaded bias set is discarded.
- Latency: 1 cycle from accumulator pop to output_V_write high.
- Throughput: 1 word per cycle in RUN while the accumulator FIFO is non-empty and the output is not stalled.
- Backpressure: with output_V_full_n=0 and out_vld=1, acc_V_read=0, and output_V_din/output_V_write hold stable.
- Empty inputs: acc_V_empty_n=0 in RUN, or bias_V_empty_n=0 in LOAD, is an idle cycle with no counter change.
- Frame boundary: the last result may drain from the output register while the FSM is already in LOAD. Loading the next frame's biases overlaps that drain.
- First read of the next frame: bias_mem is fully rewritten before any RUN-state read. The first accumulator pop happens no earlier than the cycle after the N_CH-th bias pop.

## Structure
- Shared constants stay in `layers_sizes.vh` (`kern_s_k_11`) and `my_types.vh` (`coeff_width`). Add `acc_width` to `my_types.vh`; it is the default for ACC_W.
- Counter widths are $clog2(N_CH) and $clog2(N_PIX), each with a minimum of 1.
- Sub-module `sat_add`: a combinational signed adder with clamp, parameterised by ACC_W and COEFF_W. Reused by later bias stages.

## Test plan
- N_CH=4, N_PIX=2. Biases 1, −2, 3, −4. Accumulators 10,10,10,10,−5,−5,−5,−5 → outputs 11, 8, 13, 6, −4, −7, −2, −9. frame_done pulses on the 8th accepted write.
- ACC_W=32, bias 1 on accumulator 0x7FFFFFFF → output 0x7FFFFFFF. Bias −1 on 0x80000000 → output 0x80000000.
- output_V_full_n held low for 5 cycles mid-stream → output_V_din held stable, acc_V_read=0 throughout, no word lost or duplicated.
- Two back-to-back frames with different bias sets, with the second bias set available early → no acc_V_read until all 4 new biases are popped, and frame 2 uses only the new values.
- ap_rst pulsed after 2 of 4 bias pops → all outputs 0. The next load restarts at bias_mem[0] and all subsequent results are correct.
- Randomised empty_n/full_n gaps over 3 frames compared against a scoreboard model → exact match, one frame_done per frame.
